// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_sub_cell.sv
// One-bit full subtractor assembled from two half-subtractor cells
// (diff = a^b, borr = ~a&b) with the two borrows ORed together.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borr
);

    assign diff = a ^ b;
    assign borr = ~a & b;

endmodule

module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d0;
    logic b0;
    logic b1;

    half_subtractor u_hs0 (
        .a    (x),
        .b    (y),
        .diff (d0),
        .borr (b0)
    );

    half_subtractor u_hs1 (
        .a    (d0),
        .b    (bin),
        .diff (d),
        .borr (b1)
    );

    assign bout = b0 | b1;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first, registered borrow).
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borr
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             bo_bit;
    logic             last_bit;

    full_sub_cell u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (bo_bit)
    );

    // Result bits are shifted into the vacated top of a_sr, so after WIDTH
    // shifts a_sr holds the difference without a separate result register.
    if (WIDTH == 1) begin : g_res_w1
        assign res_nxt = d_bit;
    end else begin : g_res_wn
        assign res_nxt = {d_bit, a_sr[WIDTH-1:1]};
    end

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            borr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= res_nxt;
                    b_sr <= b_sr >> 1;
                    br   <= bo_bit;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff <= res_nxt;
                        borr <= bo_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (state == SHIFT && last_bit) begin
                ovf <= (a_msb ^ b_msb) & (a_msb ^ res_nxt[WIDTH-1]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borr;

    logic       w1_in_valid;
    logic       w1_in_ready;
    logic [0:0] w1_a;
    logic [0:0] w1_b;
    logic       w1_out_valid;
    logic       w1_out_ready;
    logic [0:0] w1_diff;
    logic       w1_borr;

`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
    logic       w1_ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] vec_a    [5] = '{8'h12, 8'h00, 8'hFF, 8'h00, 8'h80};
    logic [7:0] vec_b    [5] = '{8'h35, 8'h00, 8'hFF, 8'hFF, 8'h01};
    logic [7:0] vec_diff [5] = '{8'hDD, 8'h00, 8'h00, 8'h01, 8'h7F};
    logic       vec_borr [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       vec_ovf  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic       w1_exp_d [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       w1_exp_b [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       w1_exp_o [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borr      (borr)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u_dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .a         (w1_a),
        .b         (w1_b),
        .out_valid (w1_out_valid),
        .out_ready (w1_out_ready),
        .diff      (w1_diff),
        .borr      (w1_borr)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (w1_ovf)
`endif
    );

    // Presents one operand pair, then waits (bounded) for out_valid.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv,
                            output int cyc, output bit busy_ok);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        cyc      = 0;
        busy_ok  = 1'b1;
        while (out_valid !== 1'b1 && cyc < 50) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        a            = 8'h00;
        b            = 8'h00;
        out_ready    = 1'b0;
        w1_in_valid  = 1'b0;
        w1_a         = 1'b0;
        w1_b         = 1'b0;
        w1_out_ready = 1'b0;
        #22;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (diff !== 8'h00 || borr !== 1'b0) begin
            errors++;
            $display("FAIL reset_diff_borr: got %h/%b want 00/0", diff, borr);
        end
        checks++;
        if (w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_w1: got in_ready=%b out_valid=%b want 1/0", w1_in_ready, w1_out_valid);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int cyc;
        bit busy_ok;
        start_op(8'h35, 8'h12, cyc, busy_ok);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles want 8", cyc);
        end
        checks++;
        if (diff !== 8'h23 || borr !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %h/%b want 23/0", diff, borr);
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            errors++;
            $display("FAIL basic_in_ready_busy: got in_ready high during op, want low");
        end
        finish_op();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        int cyc;
        bit busy_ok;
        for (int i = 0; i < 5; i++) begin
            start_op(vec_a[i], vec_b[i], cyc, busy_ok);
            checks++;
            if (cyc !== 8) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d want 8", i, cyc);
            end
            checks++;
            if (diff !== vec_diff[i] || borr !== vec_borr[i]) begin
                errors++;
                $display("FAIL vec%0d_result: %h-%h got %h/%b want %h/%b", i,
                         vec_a[i], vec_b[i], diff, borr, vec_diff[i], vec_borr[i]);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ovf !== vec_ovf[i]) begin
                errors++;
                $display("FAIL vec%0d_ovf: got %b want %b", i, ovf, vec_ovf[i]);
            end
`endif
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit busy_ok;
        start_op(8'h50, 8'h20, cyc, busy_ok);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL bp_latency: got %0d want 8", cyc);
        end
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || diff !== 8'h30 || borr !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got ov=%b diff=%h borr=%b ir=%b want 1/30/0/0",
                         i, out_valid, diff, borr, in_ready);
            end
        end
        in_valid = 1'b0;
        finish_op();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit busy_ok;
        bit seen_valid;
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_abort: got ov=%b ir=%b diff=%h want 0/1/00", out_valid, in_ready, diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_pulse: got out_valid pulse want none");
        end
        checks++;
        if (in_ready !== 1'b1 || diff !== 8'h00 || borr !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: got ir=%b diff=%h borr=%b want 1/00/0", in_ready, diff, borr);
        end
        start_op(8'h0A, 8'h03, cyc, busy_ok);
        checks++;
        if (cyc !== 8 || diff !== 8'h07 || borr !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_next_op: got %0d cycles %h/%b want 8 07/0", cyc, diff, borr);
        end
        finish_op();
    endtask

    task automatic test_width1();
        int cyc;
        logic [1:0] ab;
        for (int i = 0; i < 4; i++) begin
            ab          = 2'(i);
            w1_a        = ab[1];
            w1_b        = ab[0];
            w1_in_valid = 1'b1;
            @(posedge clk);
            #1;
            w1_in_valid = 1'b0;
            cyc = 0;
            while (w1_out_valid !== 1'b1 && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            checks++;
            if (cyc !== 1) begin
                errors++;
                $display("FAIL w1_latency%0d: got %0d want 1", i, cyc);
            end
            checks++;
            if (w1_diff !== w1_exp_d[i] || w1_borr !== w1_exp_b[i]) begin
                errors++;
                $display("FAIL w1_result%0d: a=%b b=%b got %b/%b want %b/%b", i,
                         ab[1], ab[0], w1_diff, w1_borr, w1_exp_d[i], w1_exp_b[i]);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (w1_ovf !== w1_exp_o[i]) begin
                errors++;
                $display("FAIL w1_ovf%0d: got %b want %b", i, w1_ovf, w1_exp_o[i]);
            end
`endif
            w1_out_ready = 1'b1;
            @(posedge clk);
            #1;
            w1_out_ready = 1'b0;
            checks++;
            if (w1_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL w1_idle%0d: got in_ready=%b want 1", i, w1_in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
